// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared types and helpers for the sipo_rx serial receiver.
//   state_t   : receiver FSM states (PARITY used only with SIPO_RX_PARITY_EN)
//   cnt_width : bit-counter width for a given word width
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_rx_shift.sv
// sipo_rx_shift: WIDTH-bit capture register with indexed single-bit write
// and whole-register clear. A clear and a write in the same cycle give a
// register holding only the written bit.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear all bits
//   wr_en    : write wr_bit at position wr_idx
//   q        : register contents
module sipo_rx_shift
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_idx,
  input  logic          wr_bit,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    if (clr) q_nxt = '0;
    if (wr_en) q_nxt[wr_idx] = wr_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-in, parallel-out receiver with a one-entry
// valid/ready output buffer, framing-restart and overrun pulses.
// Optional feature macro: SIPO_RX_PARITY_EN (one even-parity bit per word).
//   clk, rst              : clock, synchronous active-high reset
//   sin_valid, sin        : bit strobe and serial data bit
//   sin_start             : sampled bit is bit 0 of a new word
//   dout, dout_valid      : buffered word and its valid flag
//   dout_ready            : consumer accepts dout
//   dout_perr             : parity error for the word in dout
//   busy                  : word partially received
//   overrun, frame_err    : one-cycle event pulses
//
// state  | meaning
// IDLE   | waiting for a sin_start bit
// SHIFT  | collecting data bits 1..WIDTH-1
// PARITY | waiting for the parity bit (SIPO_RX_PARITY_EN only)
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_perr,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count, cnt_nxt;
  logic             sr_clr, sr_wr;
  logic [CW-1:0]    sr_idx;
  logic [WIDTH-1:0] sr_q;
  logic             commit, commit_perr, ferr_nxt;
  logic [WIDTH-1:0] commit_word;

  sipo_rx_shift #(.WIDTH(WIDTH), .CW(CW)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .clr    (sr_clr),
    .wr_en  (sr_wr),
    .wr_idx (sr_idx),
    .wr_bit (sin),
    .q      (sr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = count;
    sr_clr      = 1'b0;
    sr_wr       = 1'b0;
    sr_idx      = count;
    commit      = 1'b0;
    commit_word = sr_q;
    commit_perr = 1'b0;
    ferr_nxt    = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        // A start bit always begins a fresh word; outside IDLE it abandons one.
        ferr_nxt  = (state != IDLE);
        sr_clr    = 1'b1;
        sr_wr     = 1'b1;
        sr_idx    = '0;
        cnt_nxt   = CW'(1);
        state_nxt = SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            sr_wr = 1'b1;
            if (count == LAST) begin
              cnt_nxt = '0;
`ifdef SIPO_RX_PARITY_EN
              state_nxt = PARITY;
`else
              // The last bit is still in flight to the register; merge it here.
              commit                 = 1'b1;
              commit_word[WIDTH-1]   = sin;
              state_nxt              = IDLE;
`endif
            end else begin
              cnt_nxt = count + CW'(1);
            end
          end
`ifdef SIPO_RX_PARITY_EN
          PARITY: begin
            commit      = 1'b1;
            commit_perr = ^{sr_q, sin};
            state_nxt   = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_perr  <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= ferr_nxt;
      if (commit && (!dout_valid || dout_ready)) begin
        dout       <= commit_word;
        dout_perr  <= commit_perr;
        dout_valid <= 1'b1;
      end else begin
        if (commit) overrun <= 1'b1;
        if (dout_valid && dout_ready) dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver that sits directly downstream of the team's parallel-to-serial shifter. Assembles an LSB-first serial bit stream into WIDTH-bit words, framed by a start marker on the first bit. Presents each word through a one-entry valid/ready output buffer. Flags framing restarts and overruns.

## Interface
- WIDTH, default 8: data word width in bits, minimum 2.
- clk  in  1: clock; all state changes on the rising edge.
- rst  in  1: synchronous, active-high reset.
- sin_valid  in  1: bit strobe; sin is sampled on every edge where this is high.
- sin  in  1: serial data bit, LSB of the word first.
- sin_start  in  1: marks the sampled bit as bit 0 of a new word; meaningful only with sin_valid.
- dout  out  WIDTH: assembled word; stable while dout_valid is high.
- dout_valid  out  1: output buffer holds a word.
- dout_ready  in  1: consumer accepts dout when high together with dout_valid.
- dout_perr  out  1: parity error flag for the word in dout; qualified by dout_valid.
- busy  out  1: high while a word is partially received (state not IDLE).
- overrun  out  1: one-cycle pulse; a completed word was dropped because the buffer was full.
- frame_err  out  1: one-cycle pulse; a partial word was abandoned by a new sin_start.

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with the parity macro.
- IDLE:
  - sin_valid && sin_start: sin goes to bit 0, count=1, go to SHIFT.
  - sin_valid without sin_start: the bit is ignored.
- SHIFT:
  - sin_valid && !sin_start: sin goes to bit[count], count++.
  - sin_valid && sin_start: abandon the partial word, pulse frame_err, take sin as bit 0, count=1, stay in SHIFT.
  - Capture of bit WIDTH-1 completes the data bits. With parity, go to PARITY. Without parity, commit and go to IDLE.
- PARITY: the next sin_valid bit is the parity bit (even parity: XOR of data and parity bit = 0). Commit, then go to IDLE. sin_start here abandons the word exactly as in SHIFT.
- Commit, on the completing edge:
  - If the buffer is empty, or is drained on that same edge (dout_valid && dout_ready), load dout and dout_perr and set dout_valid.
  - Otherwise drop the new word, keep the buffered word unchanged, and pulse overrun.
- Buffer: dout_valid clears on dout_valid && dout_ready, unless a commit on the same edge reloads it.
- Counter is $clog2(WIDTH) bits and never exceeds WIDTH-1.
- Reset values:
  - state IDLE, count 0, shift register 0.
  - dout 0, dout_valid 0, dout_perr 0.
  - busy 0, overrun 0, frame_err 0.
- Reset mid-word discards the partial word and any buffered word.

## Timing
- dout_valid rises one cycle after the edge that samples the last bit (data bit, or parity bit if enabled).
- Back-to-back words are sustained: sin_start is accepted in the cycle immediately after completion. Throughput is one bit per cycle when sin_valid is held high.
- dout is registered; no combinational path from sin to dout.
- There is a combinational path from dout_ready to the commit decision only; no output depends combinationally on inputs.
- overrun and frame_err are registered pulses, high for exactly one cycle after the causing edge.

## Configuration
- SIPO_RX_PARITY_EN defined:
  - PARITY state present; one extra even-parity bit follows each word.
  - dout_perr = 1 when the received parity is wrong. The word is still delivered.
- Not defined:
  - No PARITY state; a word completes on bit WIDTH-1.
  - dout_perr tied 0; port list unchanged.

## Structure
- Package sipo_rx_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - a helper function for counter width.
- Sub-module sipo_rx_shift: WIDTH-bit shift/capture register with indexed bit write and clear. The FSM, commit logic and output buffer stay in sipo_rx.

## Test plan
- WIDTH=8, no parity: bits 1,0,1,0,0,1,0,1 with sin_start on the first, dout_ready=1 -> dout=0xA5 with dout_valid high for one cycle, one cycle after the eighth bit.
- Two words 0xA5 then 0x3C back-to-back, dout_ready=0 until both complete -> dout holds 0xA5, one overrun pulse at 0x3C completion, 0x3C lost.
- sin_start after 3 bits of a word, then 8 bits of 0x0F -> one frame_err pulse, dout=0x0F, no overrun.
- rst asserted after 5 bits of a word and with a word buffered -> dout_valid=0, busy=0, dout=0 next cycle; a following full 0x81 is received correctly.
- SIPO_RX_PARITY_EN, 0xA5 with parity bit 0 -> dout=0xA5, dout_perr=0. Same with parity bit 1 -> dout_perr=1.
- Buffer full; consumer asserts dout_ready on the same edge the next word completes -> no overrun, and the new word is in dout the next cycle.
